// File: rtl/mux_rr_scheduler_pkg.sv
// Shared definitions for the round-robin 4:1 registered mux scheduler:
// requester count, select width, FSM state type and the select-to-grant
// decode used by the scheduler top.
package mux_sched_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Turn a requester index into its one-hot grant vector.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Requester/consumer bus of the round-robin mux scheduler. The master side
// presents the four request lines and data words and observes the grant and
// the registered output beat. The slave side is the scheduler itself.
interface mux_rr_scheduler_if #(
    parameter int DW = 8
) ();
    import mux_sched_pkg::*;

    // Requester side
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] in_data;

    // Arbitration state visible to requesters
    logic [N_REQ-1:0]    gnt;
    logic [SEL_W-1:0]    sel;

    // Registered output beat towards the single-port consumer
    logic [DW-1:0]       out_data;
    logic                out_valid;
    logic [SEL_W-1:0]    out_id;
    logic                out_last;

    modport master (
        output req, in_data,
        input  gnt, sel, out_data, out_valid, out_id, out_last
    );

    modport slave (
        input  req, in_data,
        output gnt, sel, out_data, out_valid, out_id, out_last
    );

endinterface

// File: rtl/mux_rr_scheduler_rr_picker.sv
// Rotating-priority picker: returns the first asserted request found when
// scanning from index i_ptr upward, wrapping modulo N_REQ. Purely
// combinational.
module rr_picker
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic             o_any,
    output logic [SEL_W-1:0] o_idx
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]   w_enc;

    // Rotate so that requester i_ptr lands on bit 0: w_rot[k] = i_req[(k+ptr)%N].
    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[i_ptr +: N_REQ];

    // Fixed-priority encode of the rotated vector, lowest bit wins.
    always_comb begin
        // NOTE: default first so every path assigns w_enc and no latch is inferred.
        w_enc = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_enc = SEL_W'(k);
            end
        end
    end

    // Undo the rotation; the add wraps naturally in SEL_W bits.
    assign o_idx = w_enc + i_ptr;
    assign o_any = |i_req;

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler in front of a registered 4:1 data mux. One grant is
// held for at most MAX_BURST beats; a requester that drops its request ends
// its grant early. The priority pointer moves to the slot after the released
// requester, and re-arbitration happens on the same edge as the release so
// that back-to-back full bursts have no idle cycle in between.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux_rr_scheduler_if.slave  bus
);

    localparam int                CNT_W    = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_BURST - 1);

    // Control registers
    state_t            r_state;
    logic [SEL_W-1:0]  r_ptr;
    logic [SEL_W-1:0]  r_sel;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_REQ-1:0]  r_gnt;

    // Output beat registers
    logic [DW-1:0]     r_out_data;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_out_id;
    logic              r_out_last;

    // Combinational helpers
    logic [SEL_W-1:0]  w_next_ptr;
    logic [SEL_W-1:0]  w_pick_ptr;
    logic              w_any;
    logic [SEL_W-1:0]  w_idx;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_release;
    logic [DW-1:0]     w_sel_data;

    // Slot after the current holder; becomes the pointer on release.
    assign w_next_ptr = r_sel + SEL_W'(1);

    // A single picker serves both cases: from IDLE it scans from the stored
    // pointer, while holding a grant it is only consulted on release, where
    // the new pointer is sel+1. The released requester therefore sits last
    // in the scan and only wins if nobody else is requesting.
    assign w_pick_ptr = (r_state == GRANT) ? w_next_ptr : r_ptr;

    rr_picker u_picker (
        .i_req (bus.req),
        .i_ptr (w_pick_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    // A beat is taken only while the granted requester still requests.
    assign w_beat      = bus.req[r_sel];
    assign w_last_beat = (r_cnt == LAST_CNT);
    assign w_release   = !w_beat || w_last_beat;
    assign w_sel_data  = bus.in_data[r_sel*DW +: DW];

    // Arbitration FSM plus registered data path; every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments throughout so all state updates
            // see the pre-edge values, exactly like the hardware flops.
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    if (w_any) begin
                        r_state <= GRANT;
                        r_gnt   <= onehot(w_idx);
                        r_sel   <= w_idx;
                        r_cnt   <= '0;
                    end
                end

                GRANT: begin
                    if (w_beat) begin
                        r_out_data  <= w_sel_data;
                        r_out_valid <= 1'b1;
                        r_out_id    <= r_sel;
                        r_cnt       <= r_cnt + CNT_W'(1);
                        r_out_last  <= w_last_beat;
                    end else begin
                        // Early drop: no beat, and a truncated burst never
                        // reports out_last. out_data/out_id keep the last beat.
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end

                    if (w_release) begin
                        r_ptr <= w_next_ptr;
                        r_cnt <= '0;
                        if (w_any) begin
                            r_gnt <= onehot(w_idx);
                            r_sel <= w_idx;
                        end else begin
                            r_gnt   <= '0;
                            r_state <= IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.sel       = r_sel;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_id    = r_out_id;
    assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler (DW=8, MAX_BURST=4): a table of
// per-cycle vectors for reset and full round-robin rotation, hand-written
// sequences for sole requester, early drop, mid-burst reset and pointer
// placement, and per-cycle invariant checks.
module tb_mux_rr_scheduler;
    import mux_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_rr_scheduler_if #(.DW(8)) bus ();

    mux_rr_scheduler #(
        .DW        (8),
        .MAX_BURST (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge, then sample away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic v, input logic [1:0] id, input logic [7:0] d,
                             input logic l);
        check({tag, ".gnt"},       bus.gnt,       g);
        check({tag, ".sel"},       bus.sel,       s);
        check({tag, ".out_valid"}, bus.out_valid, v);
        check({tag, ".out_id"},    bus.out_id,    id);
        check({tag, ".out_data"},  bus.out_data,  d);
        check({tag, ".out_last"},  bus.out_last,  l);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (g[k]) r = 2'(k);
        end
        return r;
    endfunction

    // Invariants, sampled on the falling edge.
    bit         inv_en = 1'b0;
    logic [1:0] prev_sel;

    always @(negedge clk) begin
        if (inv_en) begin
            check("inv.gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
            check("inv.gnt_vs_state", 32'(bus.gnt != 4'b0), 32'(dut.r_state == GRANT));
            if (bus.gnt != 4'b0) check("inv.sel_index", bus.sel, idx_of(bus.gnt));
            if (bus.out_valid)   check("inv.out_id_prev_sel", bus.out_id, prev_sel);
            prev_sel = bus.sel;
        end
    end

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       v;
        logic [1:0] id;
        logic [7:0] d;
        logic       l;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [3:0] q, logic [3:0] g, logic [1:0] s,
                                logic v, logic [1:0] id, logic [7:0] d, logic l);
        vec_t t;
        t.rst = r; t.req = q; t.gnt = g; t.sel = s;
        t.v = v; t.id = id; t.d = d; t.l = l;
        return t;
    endfunction

    initial begin
        logic [1:0] nxt;

        rst         = 1'b1;
        bus.req     = 4'b1111;
        bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};

        // Reset held two edges with all requesting, then full rotation.
        vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0));
        for (int i = 0; i < 4; i++) begin
            nxt = 2'(i + 1);
            for (int b = 0; b < 3; b++)
                vecs.push_back(mk(1'b0, 4'b1111, onehot(2'(i)), 2'(i), 1'b1, 2'(i), 8'(8'h10 + i), 1'b0));
            vecs.push_back(mk(1'b0, 4'b1111, onehot(nxt), nxt, 1'b1, 2'(i), 8'(8'h10 + i), 1'b1));
        end
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 2'd0, 8'h10, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst     = vecs[i].rst;
            bus.req = vecs[i].req;
            step();
            inv_en = 1'b1;
            check_out($sformatf("tbl[%0d]", i), vecs[i].gnt, vecs[i].sel, vecs[i].v,
                      vecs[i].id, vecs[i].d, vecs[i].l);
        end

        // Sole requester 2: continuous beats, out_last on beats 4 and 8.
        do_reset();
        bus.in_data = {8'h13, 8'hA5, 8'h11, 8'h10};
        bus.req     = 4'b0100;
        step();
        check_out("sole.grant", 4'b0100, 2'd2, 1'b0, 2'd0, 8'h00, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            check_out($sformatf("sole.beat%0d", k), 4'b0100, 2'd2, 1'b1, 2'd2, 8'hA5,
                      (k % 4) == 0);
        end

        // Early drop of requester 0 after two beats.
        do_reset();
        bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req     = 4'b0101;
        step();
        check_out("drop.grant", 4'b0001, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0);
        step();
        check_out("drop.beat1", 4'b0001, 2'd0, 1'b1, 2'd0, 8'h10, 1'b0);
        step();
        check_out("drop.beat2", 4'b0001, 2'd0, 1'b1, 2'd0, 8'h10, 1'b0);
        bus.req = 4'b0100;
        step();
        check_out("drop.gap", 4'b0100, 2'd2, 1'b0, 2'd0, 8'h10, 1'b0);
        step();
        check_out("drop.next", 4'b0100, 2'd2, 1'b1, 2'd2, 8'h12, 1'b0);

        // Reset in the middle of a burst.
        do_reset();
        bus.req = 4'b1111;
        step();
        step();
        step();
        check_out("midrst.beat2", 4'b0001, 2'd0, 1'b1, 2'd0, 8'h10, 1'b0);
        rst     = 1'b1;
        bus.req = 4'b1010;
        step();
        check_out("midrst.reset", 4'b0000, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0);
        check("midrst.ptr", dut.r_ptr, 2'd0);
        check("midrst.cnt", dut.r_cnt, 3'd0);
        rst = 1'b0;
        step();
        check_out("midrst.regrant", 4'b0010, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0);

        // Requester 1 releases into IDLE (ptr=2), then 1010 picks requester 3.
        step();
        check_out("ptr.beat", 4'b0010, 2'd1, 1'b1, 2'd1, 8'h11, 1'b0);
        bus.req = 4'b0000;
        step();
        check_out("ptr.idle", 4'b0000, 2'd1, 1'b0, 2'd1, 8'h11, 1'b0);
        check("ptr.value", dut.r_ptr, 2'd2);
        bus.req = 4'b1010;
        step();
        check_out("ptr.grant3", 4'b1000, 2'd3, 1'b0, 2'd1, 8'h11, 1'b0);
        step();
        check_out("ptr.beat3", 4'b1000, 2'd3, 1'b1, 2'd3, 8'h13, 1'b0);

        @(negedge clk);
        inv_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
